// File: rtl/inst_fetch_queue_if.sv
// Handshake and bus bundle between the fetch queue, the instruction ROM,
// the decode stage and the redirect sources (branch in decode, exception in WB).
interface inst_fetch_queue_if;
    logic [31:0] inst_addr;    // ROM address, sampled by the ROM at the clock edge
    logic [31:0] inst;         // ROM data, one cycle after the address
    logic [32:0] jbr_bus;      // {taken, target}
    logic [32:0] exc_bus;      // {valid, target}
    logic        ID_allow_in;  // decode can accept an instruction
    logic        IF_over;      // queue head valid
    logic [63:0] IF_ID_bus;    // {pc, inst} of queue head
    logic [31:0] IF_pc;        // head pc
    logic [31:0] IF_inst;      // head instruction
    logic [1:0]  q_count;      // occupancy

    // Environment side: ROM, decode and write-back
    modport master (
        output inst, jbr_bus, exc_bus, ID_allow_in,
        input  inst_addr, IF_over, IF_ID_bus, IF_pc, IF_inst, q_count
    );

    // Fetch-queue side
    modport slave (
        input  inst, jbr_bus, exc_bus, ID_allow_in,
        output inst_addr, IF_over, IF_ID_bus, IF_pc, IF_inst, q_count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch with a 2-entry prefetch FIFO of {pc, inst} pairs.
// Issues fetch_pc to a synchronous ROM, captures the returning word a cycle
// later, and hands the FIFO head to decode. Branches keep their delay slot;
// exceptions flush everything.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    inst_fetch_queue_if.slave bus
);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_inflight;
    logic        r_pend_jbr;
    logic [31:0] r_pend_tgt;

    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_inst [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_exc;
    logic [31:0] w_exc_tgt;
    logic        w_jbr;
    logic [31:0] w_jbr_tgt;
    logic        w_head_valid;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_proj;
    logic        w_issue;
    logic [31:0] w_head_pc;
    logic [31:0] w_head_inst;

    // Exception has priority: a simultaneous branch is ignored.
    assign w_exc     = bus.exc_bus[32];
    assign w_exc_tgt = bus.exc_bus[31:0];
    assign w_jbr     = bus.jbr_bus[32] & ~w_exc;
    assign w_jbr_tgt = bus.jbr_bus[31:0];

    assign w_head_valid = (r_count != 2'd0);
    assign w_pop        = w_head_valid & bus.ID_allow_in;

    // Occupancy once the current read lands and the pop completes; a new
    // request is only safe if that leaves room for its data next cycle.
    assign w_proj  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = ~w_exc & ~w_jbr & (w_proj <= 3'd1);

    // Returning data is kept unless flushed. Under a branch it survives only
    // when the queue is empty, since it is then the delay slot.
    assign w_push = r_inflight & ~w_exc & ~(w_jbr & w_head_valid);

    // Store returning ROM words at the tail of the FIFO
    // NOTE: the data array has no reset; every read is qualified by r_count,
    // so stale contents can never reach the outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
            r_fifo_inst[r_wr_ptr] <= bus.inst;
        end
    end

    // FIFO pointers and occupancy, including branch/exception trimming
    // NOTE: all state uses non-blocking assignment so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (w_exc || (w_jbr && w_pop)) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (w_jbr && w_head_valid) begin
            // Keep only the head, which is the delay slot.
            r_wr_ptr <= r_rd_ptr + 1'b1;
            r_count  <= 2'd1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Fetch address, outstanding-request tracking and delayed branch target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= 32'h0;
            r_inflight <= 1'b0;
            r_pend_jbr <= 1'b0;
            r_pend_tgt <= 32'h0;
        end else begin
            r_inflight <= w_issue;
            if (w_exc) begin
                r_fetch_pc <= w_exc_tgt;
                r_pend_jbr <= 1'b0;
            end else if (w_jbr) begin
                if (w_head_valid || r_inflight) begin
                    // Delay slot is already queued or returning now.
                    r_fetch_pc <= w_jbr_tgt;
                    r_pend_jbr <= 1'b0;
                end else begin
                    // Delay slot not yet requested: fetch it first.
                    r_pend_jbr <= 1'b1;
                    r_pend_tgt <= w_jbr_tgt;
                end
            end else if (w_issue) begin
                r_req_pc <= r_fetch_pc;
                if (r_pend_jbr) begin
                    r_fetch_pc <= r_pend_tgt;
                    r_pend_jbr <= 1'b0;
                end else begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
            end
        end
    end

    // Head selection, forced to zero when the queue is empty
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and infers a latch.
    always_comb begin
        w_head_pc   = 32'h0;
        w_head_inst = 32'h0;
        if (w_head_valid) begin
            w_head_pc   = r_fifo_pc[r_rd_ptr];
            w_head_inst = r_fifo_inst[r_rd_ptr];
        end
    end

    assign bus.inst_addr = r_fetch_pc;
    assign bus.IF_over   = w_head_valid;
    assign bus.IF_pc     = w_head_pc;
    assign bus.IF_inst   = w_head_inst;
    assign bus.IF_ID_bus = {w_head_pc, w_head_inst};
    assign bus.q_count   = r_count;

endmodule
